// File: rtl/sram_fifo_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing the SRAM FIFO AXI4-Stream write path
// between C_NUM_PORTS sources; a granted port keeps the output until its tlast beat.
module sram_fifo_rr_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_PORTS        = 4
) (
    input  logic                                            aclk,
    input  logic                                            aresetn,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [C_NUM_PORTS*(C_AXIS_DATA_WIDTH/8)-1:0]    s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]       s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                          s_axis_tvalid,
    output logic [C_NUM_PORTS-1:0]                          s_axis_tready,
    input  logic [C_NUM_PORTS-1:0]                          s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]                    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                   m_axis_tuser,
    output logic                                            m_axis_tvalid,
    input  logic                                            m_axis_tready,
    output logic                                            m_axis_tlast,
    output logic [2:0]                                      grant,
    output logic                                            busy,
    output logic [7:0]                                      pkt_count
);
    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               rr_ptr_q, rr_ptr_d;
    logic [2:0]               grant_q, grant_d;
    logic [7:0]               pkt_count_q, pkt_count_d;
    logic [2*C_NUM_PORTS-1:0] valid_rot_s;
    logic                     found_s;
    logic [2:0]               sel_s;
    logic                     xfer_last_s;

    // Port index addition modulo C_NUM_PORTS in 3-bit arithmetic.
    function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 4'(C_NUM_PORTS)) begin
            sum = sum - 4'(C_NUM_PORTS);
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

    // State, pointer, grant and packet counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 3'd0;
            grant_q     <= 3'd0;
            pkt_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Circular search: rotate the valids so bit 0 is rr_ptr, take the first set bit.
    always_comb begin
        valid_rot_s = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr_q;
        found_s     = 1'b0;
        sel_s       = rr_ptr_q;
        for (int k = 0; k < C_NUM_PORTS; k++) begin
            if (valid_rot_s[k] && !found_s) begin
                found_s = 1'b1;
                sel_s   = wrap_add(rr_ptr_q, 3'(k));
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_SEND;
                    grant_d = sel_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_last_s) begin
                    state_d     = ST_IDLE;
                    rr_ptr_d    = wrap_add(grant_q, 3'd1);
                    pkt_count_d = pkt_count_q + 8'd1;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: zero-latency pass-through of the granted port while sending.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        busy          = (state_q == ST_SEND);
        if (state_q == ST_SEND) begin
            for (int i = 0; i < C_NUM_PORTS; i++) begin
                if (grant_q == 3'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
                    m_axis_tstrb     = s_axis_tstrb[i*STRB_W +: STRB_W];
                    m_axis_tuser     = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end else begin
                    s_axis_tready[i] = 1'b0;
                end
            end
        end else begin
            s_axis_tready = '0;
        end
    end

    assign xfer_last_s = busy && m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign grant       = grant_q;
    assign pkt_count   = pkt_count_q;

endmodule
